verificador_secuencia: RTL and testbench

Downstream monitor for the 4-bit arbitrary-sequence counter. It samples the counter output Q on every rising edge of C and checks it against a programmed expected sequence. It reports lock, per-cycle errors, a sticky error flag, completed periods and an error count. It closes the loop on the NAND-based counter in system simulation and in hardware, replacing manual waveform inspection.

---
 rtl/verificador_secuencia_if.sv | 25 ++
 rtl/verificador_secuencia.sv | 138 +++++++++++++
 tb/tb_verificador_secuencia.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/verificador_secuencia_if.sv
// Signal bundle between the sequence checker and whatever drives and
// observes it. The clock and reset stay outside as plain ports.
interface verificador_secuencia_if;
   logic [3:0] Q;          // counter output under check
   logic       EN;         // sample enable
   logic       CLR_ERR;    // synchronous clear of sticky flag and error count
   logic       LOCK;       // high while locked onto the sequence
   logic       ERR;        // one-cycle mismatch pulse
   logic       ERR_STICKY; // mismatch seen since last clear
   logic [3:0] IDX;        // index of the next expected element
   logic [7:0] PERIODS;    // completed matched periods, saturating
   logic [7:0] ERRCNT;     // mismatch count, saturating

   // Stimulus side: drives the counter value and controls, watches results
   modport master (
      output Q, EN, CLR_ERR,
      input  LOCK, ERR, ERR_STICKY, IDX, PERIODS, ERRCNT
   );

   // Checker side
   modport slave (
      input  Q, EN, CLR_ERR,
      output LOCK, ERR, ERR_STICKY, IDX, PERIODS, ERRCNT
   );
endinterface

// File: rtl/verificador_secuencia.sv
// Sequence checker for the 4-bit arbitrary-sequence counter. Samples Q on
// every rising edge of C, follows the programmed sequence and reports lock,
// mismatch pulses, a sticky error flag, completed periods and an error count.
module verificador_secuencia #(
   parameter int          LEN = 8,                      // valid elements, 2..16
   parameter logic [63:0] SEQ = 64'h0000_0000_08CE_F731 // element i = SEQ[4*i+3:4*i]
) (
   input  logic                    C,
   input  logic                    Rn,
   verificador_secuencia_if.slave  bus
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX  = 4'(LEN - 1);
   localparam logic [3:0] FIRST_VAL = SEQ[3:0];
   localparam logic [7:0] CNT_MAX   = 8'hFF;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_idx;
   logic [3:0] w_idx_nxt;
   logic [3:0] w_expected;
   logic       w_mismatch;
   logic       w_wrap;

   logic       r_err;
   logic       r_sticky;
   logic [7:0] r_periods;
   logic [7:0] r_errcnt;
   logic       w_err_nxt;
   logic       w_sticky_nxt;
   logic [7:0] w_periods_nxt;
   logic [7:0] w_errcnt_nxt;

   // Element the checker expects next; IDX never exceeds LEN-1
   assign w_expected = SEQ[{r_idx, 2'b00} +: 4];

   // State register: FSM state, index and all reported flags/counters
   // NOTE: every register here is a few flops, so all of them get the async reset.
   always_ff @(posedge C or negedge Rn) begin
      if (!Rn) begin
         r_state   <= HUNT;
         r_idx     <= '0;
         r_err     <= 1'b0;
         r_sticky  <= 1'b0;
         r_periods <= '0;
         r_errcnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_err     <= w_err_nxt;
         r_sticky  <= w_sticky_nxt;
         r_periods <= w_periods_nxt;
         r_errcnt  <= w_errcnt_nxt;
      end
   end

   // Next-state logic: follow the sequence, detect mismatches and period wraps
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_mismatch  = 1'b0;
      w_wrap      = 1'b0;
      if (bus.EN) begin
         case (r_state)
            HUNT: begin
               if (bus.Q == FIRST_VAL) begin
                  w_state_nxt = TRACK;
                  w_idx_nxt   = 4'd1;
               end else begin
                  w_idx_nxt   = 4'd0;
               end
            end
            TRACK, LOCKED: begin
               if (bus.Q == w_expected) begin
                  if (r_idx == LAST_IDX) begin
                     w_idx_nxt   = 4'd0;
                     w_wrap      = 1'b1;
                     w_state_nxt = LOCKED;
                  end else begin
                     w_idx_nxt   = r_idx + 4'd1;
                  end
               end else begin
                  w_mismatch = 1'b1;
                  // A wrong value that happens to be the first element restarts tracking at once
                  if (bus.Q == FIRST_VAL) begin
                     w_state_nxt = TRACK;
                     w_idx_nxt   = 4'd1;
                  end else begin
                     w_state_nxt = HUNT;
                     w_idx_nxt   = 4'd0;
                  end
               end
            end
            default: begin
               w_state_nxt = HUNT;
               w_idx_nxt   = 4'd0;
            end
         endcase
      end
   end

   // Output logic: error pulse, sticky flag and saturating counters
   always_comb begin
      w_err_nxt     = w_mismatch;
      w_sticky_nxt  = r_sticky;
      w_errcnt_nxt  = r_errcnt;
      w_periods_nxt = r_periods;
      if (w_wrap && (r_periods != CNT_MAX))
         w_periods_nxt = r_periods + 8'd1;
      // A mismatch beats a simultaneous clear: the clear wipes history, then this error counts
      if (w_mismatch) begin
         w_sticky_nxt = 1'b1;
         if (bus.CLR_ERR)
            w_errcnt_nxt = 8'd1;
         else if (r_errcnt != CNT_MAX)
            w_errcnt_nxt = r_errcnt + 8'd1;
      end else if (bus.CLR_ERR) begin
         w_sticky_nxt = 1'b0;
         w_errcnt_nxt = 8'd0;
      end
   end

   assign bus.LOCK       = (r_state == LOCKED);
   assign bus.ERR        = r_err;
   assign bus.ERR_STICKY = r_sticky;
   assign bus.IDX        = r_idx;
   assign bus.PERIODS    = r_periods;
   assign bus.ERRCNT     = r_errcnt;

endmodule

// File: tb/tb_verificador_secuencia.sv
// Self-checking bench for verificador_secuencia: a directed vector table,
// hand-written corner sequences and random stimulus against a behavioural model.
module tb_verificador_secuencia;

   localparam int LEN = 8;

   logic C;
   logic Rn;
   verificador_secuencia_if bus ();

   verificador_secuencia #(
      .LEN (LEN),
      .SEQ (64'h0000_0000_08CE_F731)
   ) dut (
      .C   (C),
      .Rn  (Rn),
      .bus (bus)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   // Expected sequence written out element by element
   logic [3:0] seq [LEN] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: "running" means a run of the sequence is in progress,
   // pos is the position expected next, locked means a full period has
   // completed since the last error.
   bit m_running;
   int m_pos;
   bit m_locked;
   bit m_err;
   bit m_sticky;
   int m_periods;
   int m_errcnt;

   typedef struct {
      logic [3:0] q;
      bit         en;
      bit         clr;
      bit         lock;
      bit         err;
      logic [3:0] idx;
      logic [7:0] periods;
      logic [7:0] errcnt;
      bit         sticky;
   } vec_t;

   vec_t tbl [32];

   function automatic vec_t v(input logic [3:0] q, input bit en, input bit clr,
                              input bit lock, input bit err, input logic [3:0] idx,
                              input logic [7:0] periods, input logic [7:0] errcnt,
                              input bit sticky);
      vec_t r;
      r.q = q; r.en = en; r.clr = clr; r.lock = lock; r.err = err;
      r.idx = idx; r.periods = periods; r.errcnt = errcnt; r.sticky = sticky;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_running = 0; m_pos = 0; m_locked = 0; m_err = 0;
      m_sticky = 0; m_periods = 0; m_errcnt = 0;
   endtask

   task automatic model_step(input logic [3:0] q, input bit en, input bit clr);
      m_err = 0;
      if (en) begin
         if (!m_running) begin
            if (q == seq[0]) begin
               m_running = 1;
               m_pos = 1;
            end
         end else if (q == seq[m_pos]) begin
            m_pos = (m_pos + 1) % LEN;
            if (m_pos == 0) begin
               m_locked = 1;
               m_periods = (m_periods < 255) ? m_periods + 1 : 255;
            end
         end else begin
            m_err = 1;
            m_locked = 0;
            m_sticky = 1;
            m_errcnt = clr ? 1 : ((m_errcnt < 255) ? m_errcnt + 1 : 255);
            if (q == seq[0]) begin
               m_pos = 1;
            end else begin
               m_running = 0;
               m_pos = 0;
            end
         end
      end
      if (clr && !m_err) begin
         m_sticky = 0;
         m_errcnt = 0;
      end
   endtask

   task automatic check_model();
      check("lock",    bus.LOCK,       m_locked);
      check("err",     bus.ERR,        m_err);
      check("sticky",  bus.ERR_STICKY, m_sticky);
      check("idx",     bus.IDX,        m_pos);
      check("periods", bus.PERIODS,    m_periods);
      check("errcnt",  bus.ERRCNT,     m_errcnt);
   endtask

   // One clock: drive inputs, step the model on the edge, compare 1 ns later
   task automatic cycle(input logic [3:0] q, input bit en, input bit clr);
      bus.Q = q; bus.EN = en; bus.CLR_ERR = clr;
      @(posedge C);
      model_step(q, en, clr);
      #1;
      check_model();
   endtask

   task automatic feed_periods(input int n);
      for (int p = 0; p < n; p++)
         for (int k = 0; k < LEN; k++)
            cycle(seq[k], 1'b1, 1'b0);
   endtask

   initial begin
      // Directed table starting straight out of reset
      tbl[0]  = v(4'h1, 1, 0, 0, 0, 4'd1, 8'd0, 8'd0, 0);
      tbl[1]  = v(4'h3, 1, 0, 0, 0, 4'd2, 8'd0, 8'd0, 0);
      tbl[2]  = v(4'h7, 1, 0, 0, 0, 4'd3, 8'd0, 8'd0, 0);
      tbl[3]  = v(4'hF, 1, 0, 0, 0, 4'd4, 8'd0, 8'd0, 0);
      tbl[4]  = v(4'hE, 1, 0, 0, 0, 4'd5, 8'd0, 8'd0, 0);
      tbl[5]  = v(4'hC, 1, 0, 0, 0, 4'd6, 8'd0, 8'd0, 0);
      tbl[6]  = v(4'h8, 1, 0, 0, 0, 4'd7, 8'd0, 8'd0, 0);
      tbl[7]  = v(4'h0, 1, 0, 1, 0, 4'd0, 8'd1, 8'd0, 0);
      tbl[8]  = v(4'h1, 1, 0, 1, 0, 4'd1, 8'd1, 8'd0, 0);
      tbl[9]  = v(4'h3, 1, 0, 1, 0, 4'd2, 8'd1, 8'd0, 0);
      tbl[10] = v(4'h5, 1, 0, 0, 1, 4'd0, 8'd1, 8'd1, 1);  // 5 instead of 7
      tbl[11] = v(4'h7, 1, 0, 0, 0, 4'd0, 8'd1, 8'd1, 1);  // hunting, no error
      tbl[12] = v(4'h1, 1, 0, 0, 0, 4'd1, 8'd1, 8'd1, 1);
      tbl[13] = v(4'h3, 1, 0, 0, 0, 4'd2, 8'd1, 8'd1, 1);
      tbl[14] = v(4'h7, 1, 0, 0, 0, 4'd3, 8'd1, 8'd1, 1);
      tbl[15] = v(4'hF, 1, 0, 0, 0, 4'd4, 8'd1, 8'd1, 1);
      tbl[16] = v(4'hE, 1, 0, 0, 0, 4'd5, 8'd1, 8'd1, 1);
      tbl[17] = v(4'hC, 1, 0, 0, 0, 4'd6, 8'd1, 8'd1, 1);
      tbl[18] = v(4'h8, 1, 0, 0, 0, 4'd7, 8'd1, 8'd1, 1);
      tbl[19] = v(4'h0, 1, 0, 1, 0, 4'd0, 8'd2, 8'd1, 1);  // relocked
      tbl[20] = v(4'h1, 1, 0, 1, 0, 4'd1, 8'd2, 8'd1, 1);
      tbl[21] = v(4'h3, 1, 0, 1, 0, 4'd2, 8'd2, 8'd1, 1);
      tbl[22] = v(4'h7, 1, 0, 1, 0, 4'd3, 8'd2, 8'd1, 1);
      tbl[23] = v(4'hF, 1, 0, 1, 0, 4'd4, 8'd2, 8'd1, 1);
      tbl[24] = v(4'h1, 1, 0, 0, 1, 4'd1, 8'd2, 8'd2, 1);  // 1 instead of E: resync
      tbl[25] = v(4'h3, 1, 0, 0, 0, 4'd2, 8'd2, 8'd2, 1);
      tbl[26] = v(4'h7, 1, 0, 0, 0, 4'd3, 8'd2, 8'd2, 1);
      tbl[27] = v(4'hA, 0, 0, 0, 0, 4'd3, 8'd2, 8'd2, 1);  // EN low holds
      tbl[28] = v(4'hB, 0, 1, 0, 0, 4'd3, 8'd2, 8'd0, 0);  // clear while disabled
      tbl[29] = v(4'hF, 1, 0, 0, 0, 4'd4, 8'd2, 8'd0, 0);
      tbl[30] = v(4'h2, 1, 1, 0, 1, 4'd0, 8'd2, 8'd1, 1);  // error beats clear
      tbl[31] = v(4'h2, 1, 1, 0, 0, 4'd0, 8'd2, 8'd0, 0);  // clear alone

      // Reset state
      Rn = 1'b0;
      bus.Q = 4'h0; bus.EN = 1'b0; bus.CLR_ERR = 1'b0;
      model_reset();
      repeat (2) @(posedge C);
      #1;
      check("rst_lock",    bus.LOCK,       0);
      check("rst_err",     bus.ERR,        0);
      check("rst_sticky",  bus.ERR_STICKY, 0);
      check("rst_idx",     bus.IDX,        0);
      check("rst_periods", bus.PERIODS,    0);
      check("rst_errcnt",  bus.ERRCNT,     0);
      Rn = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 32; i++) begin
         bus.Q = tbl[i].q; bus.EN = tbl[i].en; bus.CLR_ERR = tbl[i].clr;
         @(posedge C);
         model_step(tbl[i].q, tbl[i].en, tbl[i].clr);
         #1;
         check($sformatf("vec%0d_lock", i),    bus.LOCK,       tbl[i].lock);
         check($sformatf("vec%0d_err", i),     bus.ERR,        tbl[i].err);
         check($sformatf("vec%0d_idx", i),     bus.IDX,        tbl[i].idx);
         check($sformatf("vec%0d_periods", i), bus.PERIODS,    tbl[i].periods);
         check($sformatf("vec%0d_errcnt", i),  bus.ERRCNT,     tbl[i].errcnt);
         check($sformatf("vec%0d_sticky", i),  bus.ERR_STICKY, tbl[i].sticky);
      end

      // Build ERRCNT up to 6, then clear in the same cycle as a mismatch
      for (int k = 0; k < 6; k++) begin
         cycle(4'h1, 1'b1, 1'b0);
         cycle(4'h5, 1'b1, 1'b0);
      end
      check("errcnt_six", bus.ERRCNT, 6);
      cycle(4'h1, 1'b1, 1'b0);
      cycle(4'h5, 1'b1, 1'b1);
      check("clr_vs_err_cnt",    bus.ERRCNT,     1);
      check("clr_vs_err_sticky", bus.ERR_STICKY, 1);
      cycle(4'h5, 1'b1, 1'b1);
      check("clr_alone_cnt",    bus.ERRCNT,     0);
      check("clr_alone_sticky", bus.ERR_STICKY, 0);

      // EN low for 5 cycles with garbage mid-period while locked
      feed_periods(1);
      for (int k = 0; k < 3; k++) cycle(seq[k], 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) cycle(4'(k * 3 + 2), 1'b0, 1'b0);
      check("hold_idx",  bus.IDX,  3);
      check("hold_lock", bus.LOCK, 1);
      check("hold_err",  bus.ERR,  0);
      for (int k = 3; k < LEN; k++) cycle(seq[k], 1'b1, 1'b0);
      check("hold_resume_idx", bus.IDX, 0);

      // Random stimulus: mostly the expected element, sometimes anything
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] q;
         q = m_running ? seq[m_pos] : seq[0];
         if ($urandom_range(0, 99) < 20) q = 4'($urandom_range(0, 15));
         cycle(q, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0));
      end

      // Asynchronous reset pulse between clock edges, mid-period
      feed_periods(1);
      for (int k = 0; k < 4; k++) cycle(seq[k], 1'b1, 1'b0);
      #2;
      Rn = 1'b0;
      #1;
      check("async_lock",    bus.LOCK,       0);
      check("async_idx",     bus.IDX,        0);
      check("async_periods", bus.PERIODS,    0);
      check("async_errcnt",  bus.ERRCNT,     0);
      check("async_sticky",  bus.ERR_STICKY, 0);
      check("async_err",     bus.ERR,        0);
      model_reset();
      @(posedge C);
      #1;
      Rn = 1'b1;
      cycle(4'hE, 1'b1, 1'b0);
      check("rehunt_idx", bus.IDX, 0);
      cycle(4'h1, 1'b1, 1'b0);
      check("rehunt_track_idx", bus.IDX, 1);
      for (int k = 1; k < LEN; k++) cycle(seq[k], 1'b1, 1'b0);

      // 300 continuous periods: PERIODS must stop at 255
      feed_periods(300);
      check("periods_saturated", bus.PERIODS, 255);
      check("periods_sat_lock",  bus.LOCK,    1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
